// File: rtl/lsu_sq_ring.sv
// lsu_sq_ring: in-order circular store queue, allocated at the tail and drained from the head on ROB retire.
// Define LSU_SQ_FWD_EN to compile in the store-to-load forwarding search.
module lsu_sq_ring #(
   parameter int SQ_DEPTH   = 8,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TAG_WIDTH  = 6,
   localparam int PTR_W     = $clog2(SQ_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  i_flush,
   output logic                  o_full,
   output logic [PTR_W-1:0]      o_alloc_ptr,
   input  logic                  i_alloc_en,
   input  logic [DATA_WIDTH-1:0] i_alloc_data,
   input  logic [ADDR_WIDTH-1:0] i_alloc_addr,
   input  logic [1:0]            i_alloc_size,
   input  logic [TAG_WIDTH-1:0]  i_alloc_tag,
   input  logic                  i_rob_retire_en,
   input  logic [TAG_WIDTH-1:0]  i_rob_retire_tag,
   output logic                  o_rob_retire_stall,
   input  logic                  i_sq_retire_dc_hit,
   input  logic                  i_sq_retire_msq_full,
   output logic                  o_sq_retire_en,
   output logic [DATA_WIDTH-1:0] o_sq_retire_data,
   output logic [ADDR_WIDTH-1:0] o_sq_retire_addr,
   output logic [1:0]            o_sq_retire_size,
   input  logic                  i_fwd_en,
   input  logic [ADDR_WIDTH-1:0] i_fwd_addr,
   input  logic [1:0]            i_fwd_size,
   input  logic [PTR_W-1:0]      i_fwd_ptr,
   output logic                  o_fwd_hit,
   output logic [DATA_WIDTH-1:0] o_fwd_data,
   output logic                  o_fwd_conflict
);
   localparam int IDX_W = PTR_W - 1;

   logic [DATA_WIDTH-1:0] data_q [SQ_DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q [SQ_DEPTH];
   logic [1:0]            size_q [SQ_DEPTH];
   logic [TAG_WIDTH-1:0]  tag_q  [SQ_DEPTH];
   logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic [IDX_W-1:0]      head_idx, tail_idx;
   logic                  empty, alloc_ok, head_match, stall;

   assign head_idx    = head_q[IDX_W-1:0];
   assign tail_idx    = tail_q[IDX_W-1:0];
   assign empty       = count_q == '0;
   assign o_full      = count_q == PTR_W'(SQ_DEPTH);
   assign o_alloc_ptr = tail_q;
   assign alloc_ok    = i_alloc_en && !o_full;

   assign head_match         = !empty && i_rob_retire_en && tag_q[head_idx] == i_rob_retire_tag;
   assign stall              = i_rob_retire_en && i_sq_retire_msq_full && !i_sq_retire_dc_hit;
   assign o_sq_retire_en     = head_match && !stall;
   assign o_rob_retire_stall = stall || (i_rob_retire_en && !head_match);
   assign o_sq_retire_data   = empty ? '0 : data_q[head_idx];
   assign o_sq_retire_addr   = empty ? '0 : addr_q[head_idx];
   assign o_sq_retire_size   = empty ? '0 : size_q[head_idx];

   // flush wins over alloc and retire, but the retire handshake above stays combinational
   assign head_d  = i_flush ? '0 : head_q + PTR_W'(o_sq_retire_en);
   assign tail_d  = i_flush ? '0 : tail_q + PTR_W'(alloc_ok);
   assign count_d = i_flush ? '0 : count_q + PTR_W'(alloc_ok) - PTR_W'(o_sq_retire_en);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < SQ_DEPTH; i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
            size_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (alloc_ok) begin
            data_q[tail_idx] <= i_alloc_data;
            addr_q[tail_idx] <= i_alloc_addr;
            size_q[tail_idx] <= i_alloc_size;
            tag_q[tail_idx]  <= i_alloc_tag;
         end
      end
   end

`ifdef LSU_SQ_FWD_EN
   function automatic logic [DATA_WIDTH-1:0] zext(input logic [DATA_WIDTH-1:0] d, input logic [1:0] s);
      return s == 2'd0 ? DATA_WIDTH'(d[7:0]) :
             s == 2'd1 ? DATA_WIDTH'(d[15:0]) :
             s == 2'd2 ? DATA_WIDTH'(d[31:0]) : d;
   endfunction

   logic [PTR_W-1:0]    older_n;
   logic [ADDR_WIDTH:0] l_lo, l_hi;

   // number of valid slots older than the load, modular across the wrap bit
   assign older_n = i_fwd_ptr - head_q;
   assign l_lo    = {1'b0, i_fwd_addr};
   assign l_hi    = l_lo + ((ADDR_WIDTH + 1)'(1) << i_fwd_size);

   always_comb begin
      logic [IDX_W-1:0]    slot;
      logic [ADDR_WIDTH:0] s_lo, s_hi;
      o_fwd_hit      = 1'b0;
      o_fwd_conflict = 1'b0;
      o_fwd_data     = '0;
      slot           = '0;
      s_lo           = '0;
      s_hi           = '0;
      for (int k = 0; k < SQ_DEPTH; k++) begin
         slot = head_idx + IDX_W'(k);
         s_lo = {1'b0, addr_q[slot]};
         s_hi = s_lo + ((ADDR_WIDTH + 1)'(1) << size_q[slot]);
         if (i_fwd_en && PTR_W'(k) < count_q && PTR_W'(k) < older_n && s_lo < l_hi && l_lo < s_hi) begin
            o_fwd_hit      = addr_q[slot] == i_fwd_addr && size_q[slot] == i_fwd_size;
            o_fwd_conflict = !o_fwd_hit;
            o_fwd_data     = o_fwd_hit ? zext(data_q[slot], size_q[slot]) : '0;
         end
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd     = ^{i_fwd_en, i_fwd_addr, i_fwd_size, i_fwd_ptr};
   assign o_fwd_hit      = 1'b0;
   assign o_fwd_data     = '0;
   assign o_fwd_conflict = 1'b0;
`endif
endmodule
